cdb_arbitro: RTL and testbench
==============================

Name: cdb_arbitro

Overview:
- Common Data Bus arbiter for the Tomasulo datapath.
- Collects single-cycle results (value, Qi tag, destination) from N add/sub functional units. Each unit pulses its ready signal for exactly one clock per result.
- Buffers each unit's result in a one-entry holding register and broadcasts at most one result per cycle on the CDB to reservation stations and the register file.
- Grants the CDB round-robin (or fixed priority, see Optional Feature) among units with pending results.

Parameters:
- N_UF, 3, number of functional units (2..8)
- DATA_W, 16, result width
- TAG_W, 4, Qi tag width
- DEST_W, 3, destination register index width
- IDX_W, 3, width of the unit index (must satisfy 2^IDX_W >= N_UF)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- uf_pronto  in  N_UF  bit i = unit i presents a result this cycle (V_pronto)
- uf_valor  in  N_UF*DATA_W  unit i result in slice [i*DATA_W +: DATA_W]
- uf_tag  in  N_UF*TAG_W  unit i Qi tag, same slicing
- uf_dest  in  N_UF*DEST_W  unit i destination, same slicing
- uf_ocupado  out  N_UF  bit i = holding register i valid (issue logic must not start unit i)
- cdb_valido  out  1  CDB carries a valid broadcast this cycle
- cdb_valor  out  DATA_W  broadcast value
- cdb_tag  out  TAG_W  broadcast Qi tag
- cdb_dest  out  DEST_W  broadcast destination
- cdb_uf  out  IDX_W  index of the source unit
- erro_overflow  out  1  sticky flag: a result was dropped

Behaviour:
- Clocking and reset: one clock; reset asynchronous, active-low. While resetn=0:
  - all holding valids=0, uf_ocupado=0
  - cdb_valido=0; cdb_valor, cdb_tag, cdb_dest, cdb_uf = 0
  - erro_overflow=0, round-robin pointer ptr=0
- Reset asserted mid-operation discards all pending results immediately. Nothing is broadcast after release until new uf_pronto arrives.
- State: per unit i, hold_v[i] plus hold_valor/tag/dest. Global ptr (0..N_UF-1). Registered CDB outputs.
- Each rising edge, grant phase: evaluated on pre-edge hold_v.
  - Round-robin: search i = ptr, ptr+1, ..., wrapping modulo N_UF; the first i with hold_v[i]=1 wins.
  - On a win: cdb_valido<=1, cdb_* <= hold_*[i], cdb_uf<=i, hold_v[i]<=0, ptr<=(i+1) mod N_UF.
  - No pending entry: cdb_valido<=0, other cdb_* hold their previous values, ptr unchanged.
- Same edge, capture phase, for each i with uf_pronto[i]=1:
  - If hold_v[i]=0, or unit i was granted this edge: load hold_*[i] from the unit's slices and set hold_v[i]<=1. Capture wins over clear.
  - Otherwise: new result dropped, held entry kept unchanged, erro_overflow<=1 (sticky until reset).
- Latency: uf_pronto high in cycle c is captured at the end of c. The earliest broadcast is cycle c+1, when cdb_valido=1 for exactly one cycle per result.
- Worst-case wait with all units pending: N_UF cycles.
- A pending result is never broadcast twice. Results from the same unit are broadcast in arrival order.
- uf_ocupado = hold_v (registered). No combinational path from any input to any output.
- Width rules: values pass through unmodified, no arithmetic. The ptr increment wraps at N_UF, not at 2^IDX_W.

Optional Feature:
- Macro CDB_RR_EN.
- Defined: round-robin arbitration with ptr, as above.
- Undefined: fixed priority, lowest pending index wins. ptr logic is removed, and all else is identical.
- Test 3 has distinct expected orders for the two builds.

Test Plan:
- Reset: hold resetn=0 with uf_pronto=3'b111 -> all outputs 0. Release, idle 3 cycles -> cdb_valido stays 0.
- Single result: uf_pronto=3'b010, unit1 valor=16'h1234, tag=4'h5, dest=3'd2 -> next cycle cdb_valido=1, cdb_valor=16'h1234, cdb_tag=5, cdb_dest=2, cdb_uf=1. Following cycle cdb_valido=0 and uf_ocupado=0.
- Arbitration order: unit0 alone (valor=16'h0001) is broadcast. Then unit0 (16'h0002) and unit1 (16'h0003) are pulsed together.
  - CDB_RR_EN defined: ptr=1, broadcasts 16'h0003 then 16'h0002.
  - Undefined: 16'h0002 then 16'h0003.
- Capture on grant edge: unit0 holds 16'h00AA; uf_pronto[0]=1 with 16'h00BB on the edge unit0 is granted -> CDB shows 16'h00AA, then 16'h00BB next cycle, erro_overflow stays 0.
- Overflow: pulse all three units the same cycle (16'h0010, 16'h0020, 16'h0030). Next cycle pulse unit2 again with 16'h0099 -> erro_overflow=1. Broadcasts are 0010, 0020, 0030 only; 0099 never appears.
- Reset mid-operation: three pending results, resetn low for 1 cycle after the first broadcast -> remaining two are never broadcast, and erro_overflow=0.

Source files
------------

// File: rtl/cdb_arbitro.sv
// Common Data Bus arbiter: buffers one result per functional unit and broadcasts at most one per cycle.
// Define CDB_RR_EN for round-robin grant; otherwise the lowest pending index wins.
module cdb_arbitro #(
  parameter int N_UF   = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEST_W = 3,
  parameter int IDX_W  = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_UF-1:0]          uf_pronto,
  input  logic [N_UF*DATA_W-1:0]   uf_valor,
  input  logic [N_UF*TAG_W-1:0]    uf_tag,
  input  logic [N_UF*DEST_W-1:0]   uf_dest,
  output logic [N_UF-1:0]          uf_ocupado,
  output logic                     cdb_valido,
  output logic [DATA_W-1:0]        cdb_valor,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DEST_W-1:0]        cdb_dest,
  output logic [IDX_W-1:0]         cdb_uf,
  output logic                     erro_overflow
);

  // Handshake: uf_pronto[i] is a one-cycle valid with no ready; uf_ocupado[i] tells issue
  // logic that unit i's holding register is full, and a pulse arriving then is dropped
  // (flagged on erro_overflow) unless unit i is granted on that same edge.

  logic [N_UF-1:0]   hold_v;
  logic [DATA_W-1:0] hold_valor [N_UF];
  logic [TAG_W-1:0]  hold_tag   [N_UF];
  logic [DEST_W-1:0] hold_dest  [N_UF];

  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;
  logic [N_UF-1:0]   gnt_oh;

`ifdef CDB_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UF - 1);
  logic [IDX_W-1:0] ptr;

  // Search starts at ptr and wraps at N_UF, not at 2^IDX_W.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    for (int k = 0; k < N_UF; k++) begin
      j = int'(ptr) + k;
      if (j >= N_UF) j = j - N_UF;
      if (!gnt_found && hold_v[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(j);
        gnt_oh[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (gnt_found) begin
      ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    for (int k = 0; k < N_UF; k++) begin
      if (!gnt_found && hold_v[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(k);
        gnt_oh[k] = 1'b1;
      end
    end
  end
`endif

  // Registered CDB; payload fields keep their last value when nothing is granted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cdb_valido <= 1'b0;
      cdb_valor  <= '0;
      cdb_tag    <= '0;
      cdb_dest   <= '0;
      cdb_uf     <= '0;
    end else begin
      cdb_valido <= gnt_found;
      if (gnt_found) begin
        cdb_valor <= hold_valor[gnt_idx];
        cdb_tag   <= hold_tag[gnt_idx];
        cdb_dest  <= hold_dest[gnt_idx];
        cdb_uf    <= gnt_idx;
      end
    end
  end

  // A capture on the grant edge wins over the clear, so back-to-back results are not lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_v        <= '0;
      erro_overflow <= 1'b0;
      for (int i = 0; i < N_UF; i++) begin
        hold_valor[i] <= '0;
        hold_tag[i]   <= '0;
        hold_dest[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_UF; i++) begin
        if (uf_pronto[i] && (!hold_v[i] || gnt_oh[i])) begin
          hold_v[i]     <= 1'b1;
          hold_valor[i] <= uf_valor[i*DATA_W +: DATA_W];
          hold_tag[i]   <= uf_tag[i*TAG_W +: TAG_W];
          hold_dest[i]  <= uf_dest[i*DEST_W +: DEST_W];
        end else if (gnt_oh[i]) begin
          hold_v[i] <= 1'b0;
        end else if (uf_pronto[i]) begin
          erro_overflow <= 1'b1;
        end
      end
    end
  end

  assign uf_ocupado = hold_v;

endmodule

// File: tb/tb_cdb_arbitro.sv
// Directed self-checking bench for cdb_arbitro (N_UF=3); expected order of the arbitration
// and overflow tests follows CDB_RR_EN.
module tb_cdb_arbitro;

  localparam int N_UF   = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int DEST_W = 3;
  localparam int IDX_W  = 3;

  logic                   clock;
  logic                   resetn;
  logic [N_UF-1:0]        uf_pronto;
  logic [N_UF*DATA_W-1:0] uf_valor;
  logic [N_UF*TAG_W-1:0]  uf_tag;
  logic [N_UF*DEST_W-1:0] uf_dest;
  logic [N_UF-1:0]        uf_ocupado;
  logic                   cdb_valido;
  logic [DATA_W-1:0]      cdb_valor;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DEST_W-1:0]      cdb_dest;
  logic [IDX_W-1:0]       cdb_uf;
  logic                   erro_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  cdb_arbitro #(
    .N_UF(N_UF), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEST_W(DEST_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .uf_pronto(uf_pronto),
    .uf_valor(uf_valor),
    .uf_tag(uf_tag),
    .uf_dest(uf_dest),
    .uf_ocupado(uf_ocupado),
    .cdb_valido(cdb_valido),
    .cdb_valor(cdb_valor),
    .cdb_tag(cdb_tag),
    .cdb_dest(cdb_dest),
    .cdb_uf(cdb_uf),
    .erro_overflow(erro_overflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_uf(input int i, input logic [DATA_W-1:0] v,
                        input logic [TAG_W-1:0] t, input logic [DEST_W-1:0] d);
    uf_valor[i*DATA_W +: DATA_W] = v;
    uf_tag[i*TAG_W +: TAG_W]     = t;
    uf_dest[i*DEST_W +: DEST_W]  = d;
  endtask

  task automatic pulse(input logic [N_UF-1:0] mask);
    uf_pronto = mask;
    step();
    uf_pronto = '0;
  endtask

  task automatic check_bcast(input string tag, input logic [DATA_W-1:0] v);
    check({tag, "_valido"}, 32'(cdb_valido), 32'd1);
    check({tag, "_valor"}, 32'(cdb_valor), 32'(v));
  endtask

  // scoreboard: compare each broadcast against the next expected value
  task automatic check_next(input string tag);
    logic [DATA_W-1:0] e;
    e = exp_q.pop_front();
    check_bcast(tag, e);
  endtask

  initial begin
    resetn    = 1'b0;
    uf_pronto = '1;
    uf_valor  = '0;
    uf_tag    = '0;
    uf_dest   = '0;

    // reset with all units pulsing
    step();
    step();
    check("rst_ocupado", 32'(uf_ocupado), 32'd0);
    check("rst_valido", 32'(cdb_valido), 32'd0);
    check("rst_valor", 32'(cdb_valor), 32'd0);
    check("rst_tag", 32'(cdb_tag), 32'd0);
    check("rst_dest", 32'(cdb_dest), 32'd0);
    check("rst_uf", 32'(cdb_uf), 32'd0);
    check("rst_erro", 32'(erro_overflow), 32'd0);
    uf_pronto = '0;
    resetn    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle_valido", 32'(cdb_valido), 32'd0);
    end

    // single result from unit 1
    set_uf(1, 16'h1234, 4'h5, 3'd2);
    pulse(3'b010);
    check("single_ocupado", 32'(uf_ocupado), 32'b010);
    step();
    check_bcast("single", 16'h1234);
    check("single_tag", 32'(cdb_tag), 32'h5);
    check("single_dest", 32'(cdb_dest), 32'd2);
    check("single_uf", 32'(cdb_uf), 32'd1);
    step();
    check("single_after_valido", 32'(cdb_valido), 32'd0);
    check("single_after_ocupado", 32'(uf_ocupado), 32'd0);

    // arbitration order
    set_uf(0, 16'h0001, 4'h1, 3'd1);
    pulse(3'b001);
    step();
    check_bcast("arb_first", 16'h0001);
    check("arb_first_uf", 32'(cdb_uf), 32'd0);
    set_uf(0, 16'h0002, 4'h2, 3'd2);
    set_uf(1, 16'h0003, 4'h3, 3'd3);
    pulse(3'b011);
`ifdef CDB_RR_EN
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0002);
`else
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
`endif
    step();
    check_next("arb_a");
    step();
    check_next("arb_b");
    step();
    check("arb_done_valido", 32'(cdb_valido), 32'd0);

    // capture on the grant edge
    set_uf(0, 16'h00AA, 4'h4, 3'd4);
    pulse(3'b001);
    set_uf(0, 16'h00BB, 4'h6, 3'd5);
    pulse(3'b001);
    check_bcast("cap_old", 16'h00AA);
    check("cap_ocupado", 32'(uf_ocupado), 32'b001);
    step();
    check_bcast("cap_new", 16'h00BB);
    check("cap_new_tag", 32'(cdb_tag), 32'h6);
    check("cap_erro", 32'(erro_overflow), 32'd0);
    step();
    check("cap_done_valido", 32'(cdb_valido), 32'd0);

    // overflow: unit 2 pulsed again while still holding
    set_uf(0, 16'h0010, 4'h1, 3'd1);
    set_uf(1, 16'h0020, 4'h2, 3'd2);
    set_uf(2, 16'h0030, 4'h3, 3'd3);
    pulse(3'b111);
    check("ovf_ocupado", 32'(uf_ocupado), 32'b111);
`ifdef CDB_RR_EN
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0010);
`else
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0030);
`endif
    set_uf(2, 16'h0099, 4'h9, 3'd7);
    pulse(3'b100);
    check("ovf_erro", 32'(erro_overflow), 32'd1);
    check_next("ovf_a");
    step();
    check_next("ovf_b");
    step();
    check_next("ovf_c");
    step();
    check("ovf_done_valido", 32'(cdb_valido), 32'd0);
    check("ovf_erro_sticky", 32'(erro_overflow), 32'd1);
    check("ovf_ocupado_empty", 32'(uf_ocupado), 32'd0);

    // reset mid-operation
    set_uf(0, 16'h0101, 4'h1, 3'd1);
    set_uf(1, 16'h0202, 4'h2, 3'd2);
    set_uf(2, 16'h0303, 4'h3, 3'd3);
    pulse(3'b111);
    step();
    check("mid_first_valido", 32'(cdb_valido), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_ocupado", 32'(uf_ocupado), 32'd0);
    check("mid_rst_valido", 32'(cdb_valido), 32'd0);
    check("mid_rst_erro", 32'(erro_overflow), 32'd0);
    step();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_post_valido", 32'(cdb_valido), 32'd0);
    end
    check("mid_post_erro", 32'(erro_overflow), 32'd0);
    check("mid_post_ocupado", 32'(uf_ocupado), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
